execute_md: RTL

//  Parametrised execute stage with M/W bypass plus an iterative multiply/divide unit.

---
 rtl/execute_md.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/execute_md.sv
// Execute stage: bypassed single-cycle ALU into the M register, plus an
// iterative shift-add multiplier / restoring divider that stalls the front end.
module execute_md #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    rdata1E,
    input  logic [WIDTH-1:0]    rdata2E,
    input  logic [WIDTH-1:0]    immE,
    input  logic [WIDTH-1:0]    pcE,
    input  logic [REG_BITS-1:0] writeRegE,
    input  logic [3:0]          ALUControlE,
    input  logic [1:0]          ALUSrcE,
    input  logic                regWriteE,
    input  logic                memWriteE,
    input  logic                mem2regE,
    input  logic                branchE,
    input  logic                finishE,
    input  logic                validE,
    input  logic [1:0]          forward1,
    input  logic [1:0]          forward2,
    input  logic [WIDTH-1:0]    resultW,
    input  logic                validW,
    input  logic                flushE,
    output logic                stallE,
    output logic [WIDTH-1:0]    writeDataM,
    output logic [WIDTH-1:0]    ALUResultM,
    output logic [WIDTH-1:0]    pcM,
    output logic [REG_BITS-1:0] writeRegM,
    output logic                regWriteM,
    output logic                memWriteM,
    output logic                mem2regM,
    output logic                zeroM,
    output logic                branchM,
    output logic                finishM,
    output logic                validM
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] op1, op2, src1, src2, alu_res, md_res, res, mag1, mag2;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [3:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, start, load_m, sdiv, a_neg, b_neg, is_mul;

    always_comb begin
        op1 = rdata1E;
        if (forward1 == 2'd1 && validM)      op1 = ALUResultM;
        else if (forward1 == 2'd2 && validW) op1 = resultW;
        op2 = rdata2E;
        if (forward2 == 2'd1 && validM)      op2 = ALUResultM;
        else if (forward2 == 2'd2 && validW) op2 = resultW;
    end

    always_comb begin
        src1 = op1;
        src2 = op2;
        case (ALUSrcE)
            2'd1: src2 = immE;
            2'd2: begin src1 = pcE; src2 = WIDTH'(4); end
            default: ;
        endcase
    end

    wire [SHW-1:0] shamt = src2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            4'd0: alu_res = src1 + src2;
            4'd1: alu_res = src1 - src2;
            4'd2: alu_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            4'd3: alu_res = {{(WIDTH-1){1'b0}}, src1 < src2};
            4'd4: alu_res = src1 & src2;
            4'd5: alu_res = src1 | src2;
            4'd6: alu_res = src1 ^ src2;
            4'd7: alu_res = src1 << shamt;
            4'd8: alu_res = src1 >> shamt;
            4'd9: alu_res = $signed(src1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Signed divide runs on magnitudes; signs are reapplied at DONE.
    assign sdiv  = (ALUControlE == 4'd12) || (ALUControlE == 4'd14);
    assign a_neg = sdiv & src1[WIDTH-1];
    assign b_neg = sdiv & src2[WIDTH-1];
    assign mag1  = a_neg ? -src1 : src1;
    assign mag2  = b_neg ? -src2 : src2;

    assign start  = reset && state == IDLE && validE && !flushE && ALUControlE >= 4'd10;
    assign is_mul = (op_r == 4'd10) || (op_r == 4'd11);

    // {hi,lo} is the product/quotient shift pair; opnd holds multiplicand or divisor.
    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign shifted = {hi, lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd};

    always_comb begin
        state_nx = state;
        stallE   = 1'b0;
        case (state)
            IDLE: if (start) begin state_nx = BUSY; stallE = 1'b1; end
            BUSY: begin
                if (flushE) state_nx = IDLE;
                else begin
                    stallE = 1'b1;
                    if (cnt == CW'(1)) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (op_r)
            4'd10:        md_res = lo;
            4'd11:        md_res = hi;
            4'd12, 4'd13: md_res = neg_q ? -lo : lo;
            default:      md_res = neg_r ? -hi : hi;
        endcase
    end

    assign res    = (state == DONE) ? md_res : alu_res;
    assign load_m = !flushE && validE &&
                    ((state == IDLE && ALUControlE < 4'd10) || state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            op_r  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                op_r  <= ALUControlE;
                hi    <= '0;
                lo    <= mag1;
                opnd  <= mag2;
                // Divide by zero keeps an all-ones quotient regardless of sign.
                neg_q <= (a_neg ^ b_neg) & (src2 != '0);
                neg_r <= a_neg;
                cnt   <= CW'(WIDTH);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
                if (is_mul) begin
                    hi <= sum[WIDTH:1];
                    lo <= {sum[0], lo[WIDTH-1:1]};
                end else if (!diff[WIDTH]) begin
                    hi <= diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shifted[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeDataM <= '0;
            ALUResultM <= '0;
            pcM        <= '0;
            writeRegM  <= '0;
            zeroM      <= 1'b0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
            branchM    <= 1'b0;
            finishM    <= 1'b0;
            validM     <= 1'b0;
        end else begin
            writeDataM <= op2;
            ALUResultM <= res;
            pcM        <= pcE;
            writeRegM  <= writeRegE;
            zeroM      <= (res == '0);
            regWriteM  <= load_m & regWriteE;
            memWriteM  <= load_m & memWriteE;
            mem2regM   <= load_m & mem2regE;
            branchM    <= load_m & branchE;
            finishM    <= load_m & finishE;
            validM     <= load_m;
        end
    end
endmodule
